// File: rtl/nibble_link_pkg.sv
// Shared types for the nibble-split byte link.
// Byte assembly helper used by the receiver.
package nibble_link_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;

    typedef enum logic {
        EXPECT_FIRST  = 1'b0,
        EXPECT_SECOND = 1'b1
    } rx_state_e;

    // Join the held first nibble with the second one.
    function automatic byte_t assemble(
        input nibble_t hold,
        input nibble_t nib,
        input logic    hi_first
    );
        return hi_first ? {hold, nib} : {nib, hold};
    endfunction

endpackage

// File: rtl/nibble_link_fifo.sv
// Byte FIFO with first-word fall-through head.
// Head output keeps its last value while empty.
module nibble_link_fifo
    import nibble_link_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  byte_t         push_data,
    input  logic          pop_req,
    output logic          out_valid,
    output byte_t         out_data,
    output logic [LW-1:0] level
);

    byte_t          mem_q [DEPTH];
    byte_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [LW-1:0]  level_q, level_d;
    byte_t          last_q, last_d;
    logic           pop;

    assign out_valid = (level_q != '0);
    assign pop       = out_valid && pop_req;
    assign out_data  = out_valid ? mem_q[rd_q] : last_q;
    assign level     = level_q;

    // Pointer, level and storage updates for push/pop.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        last_d  = last_q;
        if (out_valid) begin
            last_d = mem_q[rd_q];
        end
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            last_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/nibble_link_rx.sv
// Nibble link receiver: framing check, byte
// reassembly and buffered valid/ready output.
module nibble_link_rx
    import nibble_link_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ERR_W    = 8,
    parameter bit HI_FIRST = 1'b1,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_nib,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic [LW-1:0]    fifo_level
);

    rx_state_e        state_q, state_d;
    nibble_t          hold_q, hold_d;
    logic             ferr_q, ferr_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             push;
    logic             err;
    byte_t            push_data;

    assign in_ready  = (state_q == EXPECT_FIRST)
                    || (fifo_level < LW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push_data = assemble(hold_q, in_nib, HI_FIRST);
    assign frame_err = ferr_q;
    assign err_count = cnt_q;

    // Framing FSM: next state, hold update, push and error flags.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        push    = 1'b0;
        err     = 1'b0;
        if (accept) begin
            unique case (state_q)
                EXPECT_FIRST: begin
                    if (in_first) begin
                        hold_d  = in_nib;
                        state_d = EXPECT_SECOND;
                    end else begin
                        err = 1'b1;
                    end
                end
                EXPECT_SECOND: begin
                    if (in_first) begin
                        err    = 1'b1;
                        hold_d = in_nib;
                    end else begin
                        push    = 1'b1;
                        state_d = EXPECT_FIRST;
                    end
                end
                default: state_d = EXPECT_FIRST;
            endcase
        end
    end

    // Error pulse and saturating error count.
    always_comb begin
        ferr_d = err;
        cnt_d  = cnt_q;
        if (err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EXPECT_FIRST;
            hold_q  <= '0;
            ferr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
        end
    end

    nibble_link_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop_req  (out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_nibble_link_rx.sv
// Randomized and directed bench for nibble_link_rx.
// Two instances share stimulus: HI_FIRST=1/ERR_W=8 and HI_FIRST=0/ERR_W=2.
module tb_nibble_link_rx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_nib = '0;
    logic       in_first = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready0, out_valid0, frame_err0;
    logic [7:0] out_data0, err_count0;
    logic [2:0] fifo_level0;
    logic       in_ready1, out_valid1, frame_err1;
    logic [7:0] out_data1;
    logic [1:0] err_count1;
    logic [2:0] fifo_level1;

    int vectors = 0;
    int misc = 0;

    always #5 clk = ~clk;

    nibble_link_rx #(.DEPTH(DEPTH), .ERR_W(8), .HI_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_nib(in_nib), .in_first(in_first),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .frame_err(frame_err0),
        .err_count(err_count0), .fifo_level(fifo_level0)
    );

    nibble_link_rx #(.DEPTH(DEPTH), .ERR_W(2), .HI_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_nib(in_nib), .in_first(in_first),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .frame_err(frame_err1),
        .err_count(err_count1), .fifo_level(fifo_level1)
    );

    // Behavioural model: queues of bytes per config.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0, last1;
    int         cnt0, cnt1;
    bit         pend;
    logic [3:0] hold;
    bit         fe;

    function automatic bit m_ready();
        return !pend || (q0.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            last0 = 8'h00; last1 = 8'h00;
            cnt0 = 0; cnt1 = 0;
            pend = 0; hold = 4'h0; fe = 0;
        end else begin
            bit acc;
            bit err;
            acc = in_valid && m_ready();
            err = 0;
            if (q0.size() != 0 && out_ready) last0 = q0.pop_front();
            if (q1.size() != 0 && out_ready) last1 = q1.pop_front();
            if (acc) begin
                if (!pend) begin
                    if (in_first) begin pend = 1; hold = in_nib; end
                    else err = 1;
                end else begin
                    if (in_first) begin err = 1; hold = in_nib; end
                    else begin
                        q0.push_back({hold, in_nib});
                        q1.push_back({in_nib, hold});
                        pend = 0;
                    end
                end
            end
            fe = err;
            if (err) begin
                if (cnt0 < 255) cnt0++;
                if (cnt1 < 3) cnt1++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [7:0] e0, e1;
        e0 = (q0.size() != 0) ? q0[0] : last0;
        e1 = (q1.size() != 0) ? q1[0] : last1;
        chk("in_ready0", int'(in_ready0), int'(m_ready()));
        chk("in_ready1", int'(in_ready1), int'(m_ready()));
        chk("out_valid0", int'(out_valid0), int'(q0.size() != 0));
        chk("out_valid1", int'(out_valid1), int'(q1.size() != 0));
        chk("out_data0", int'(out_data0), int'(e0));
        chk("out_data1", int'(out_data1), int'(e1));
        chk("frame_err0", int'(frame_err0), int'(fe));
        chk("frame_err1", int'(frame_err1), int'(fe));
        chk("err_count0", int'(err_count0), cnt0);
        chk("err_count1", int'(err_count1), cnt1);
        chk("fifo_level0", int'(fifo_level0), q0.size());
        chk("fifo_level1", int'(fifo_level1), q1.size());
    end

    // Present a nibble and hold it until accepted (called at posedge+1).
    task automatic send(input logic f, input logic [3:0] n);
        logic r;
        in_valid = 1'b1;
        in_first = f;
        in_nib   = n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) r = in_ready0;
            @(posedge clk);
            #1;
            if (r) begin
                in_valid = 1'b0;
                return;
            end
        end
        misc++;
        $display("FAIL send_timeout: nibble %0h not accepted", n);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] drain [4];
        logic r;
        bit want_first;
        drain[0] = 8'h22; drain[1] = 8'h33;
        drain[2] = 8'h44; drain[3] = 8'h56;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Basic byte, both nibble orders.
        send(1'b1, 4'hA);
        send(1'b0, 4'h5);
        chk("lit_a5_valid", int'(out_valid0), 1);
        chk("lit_a5", int'(out_data0), 8'hA5);
        chk("lit_5a_lofirst", int'(out_data1), 8'h5A);
        send(1'b1, 4'h3);
        send(1'b0, 4'hC);
        chk("lit_c3_lofirst", int'(out_data1), 8'hC3);

        // Framing errors and resync.
        send(1'b0, 4'h7);
        send(1'b1, 4'h1);
        send(1'b1, 4'h2);
        send(1'b0, 4'hF);
        chk("lit_2f", int'(out_data0), 8'h2F);
        chk("lit_err2", int'(err_count0), 2);
        @(posedge clk);
        #1;

        // Full FIFO back-pressure.
        out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            send(1'b1, 4'(b));
            send(1'b0, 4'(b));
        end
        chk("lit_full_level", int'(fifo_level0), 4);
        send(1'b1, 4'h5);
        in_valid = 1'b1;
        in_first = 1'b0;
        in_nib   = 4'h6;
        repeat (2) begin @(posedge clk); #1; end
        chk("lit_stall_ready", int'(in_ready0), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(1'b0, 4'h6);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_drain", int'(out_data0), int'(drain[i]));
            @(posedge clk);
            #1;
        end
        chk("lit_empty_hold", int'(out_data0), 8'h56);
        chk("lit_empty_valid", int'(out_valid0), 0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) send(1'b0, 4'(i));
        chk("lit_sat3", int'(err_count1), 3);
        chk("lit_err7", int'(err_count0), 7);

        // Reset mid-operation.
        out_ready = 1'b0;
        send(1'b1, 4'h1); send(1'b0, 4'h2);
        send(1'b1, 4'h3); send(1'b0, 4'h4);
        send(1'b1, 4'h4);
        chk("lit_pre_rst_level", int'(fifo_level0), 2);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_level", int'(fifo_level0), 0);
        chk("lit_rst_data", int'(out_data0), 0);
        chk("lit_rst_err", int'(err_count0), 0);
        chk("lit_rst_ready", int'(in_ready0), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 4'h9);
        chk("lit_post_err", int'(err_count0), 1);
        send(1'b1, 4'h4);
        send(1'b0, 4'h8);
        chk("lit_48", int'(out_data0), 8'h48);

        // Randomized traffic with sender hold rule.
        want_first = 1;
        r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || r) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_first = ($urandom_range(0, 7) == 0)
                         ? !want_first : want_first;
                in_nib   = 4'($urandom_range(0, 15));
            end
            out_ready = (c % 400 < 100) ? ($urandom_range(0, 5) == 0)
                                        : ($urandom_range(0, 2) != 0);
            @(negedge clk) r = in_ready0;
            @(posedge clk);
            #1;
            r = r && in_valid;
            if (r) want_first = !in_first;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, misc);
        $finish;
    end

endmodule
